// File: rtl/fetch_stage.sv
// Instruction fetch stage: program memory with IDLE-time load port and a registered
// fetch output. It handles stall hold, a one-bubble flush on redirect, and a HALT stop.
module fetch_stage #(
  parameter int D = 12,
  parameter int W = 9,
  parameter logic [W-1:0] HALT = 9'h1FF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  input  logic         redirect,
  input  logic         stall,
  input  logic         ld_en,
  input  logic [D-1:0] ld_addr,
  input  logic [W-1:0] ld_data,
  input  logic         start,
  output logic [W-1:0] instr,
  output logic [D-1:0] instr_pc,
  output logic         instr_valid,
  output logic         pc_hold,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t state_q, state_d;

  logic [W-1:0] mem [0:(2**D)-1];

  logic [W-1:0] instr_p1;
  logic [D-1:0] instr_pc_p1;
  logic         vld_p1;

  logic in_run;
  logic halt_hit;
  logic fetch_en;

  assign in_run   = (state_q == RUN);
  assign halt_hit = in_run & vld_p1 & (instr_p1 == HALT) & ~stall;
  // The word fetched during a redirect cycle is wrong-path, so it is never committed.
  assign fetch_en = in_run & ~redirect & ~stall & ~halt_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (halt_hit) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Program image is intentionally not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (ld_en && (state_q == IDLE) && !reset) mem[ld_addr] <= ld_data;
  end

  // ---- stage p1: fetch register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
    end else if (fetch_en) begin
      instr_p1    <= mem[prog_ctr];
      instr_pc_p1 <= prog_ctr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (in_run) begin
      if (halt_hit || redirect) vld_p1 <= 1'b0;
      else if (!stall)          vld_p1 <= 1'b1;
    end
  end

  assign instr       = instr_p1;
  assign instr_pc    = instr_pc_p1;
  assign instr_valid = vld_p1;
  assign pc_hold     = ~in_run | (stall & ~redirect);
  assign done        = (state_q == HALTED);

endmodule
